micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Parametrised microprogram sequencer, successor to the fixed-width jump decoder.
- Decodes the current microinstruction's sequencing field and selects one of NCOND condition flags with a polarity option.
- Owns the microprogram counter and a DEPTH-entry return-address stack for nested BSR/RET.
- Sits between the microinstruction ROM output and the ROM address input.

Parameters:
- AW, 10, microprogram address width (ROM depth 2^AW).
- NCOND, 4, number of condition inputs (>=1).
- DEPTH, 4, return-stack entries (>=1).
- Derived localparam CW = max(1, clog2(NCOND)), condition-select width.
- Derived localparam IW = 3 + CW + AW, sequencing-field width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- Hold  in  1  1 = freeze all state this cycle.
- B  in  IW  sequencing field: B[IW-1:IW-3]=op, B[IW-4:AW]=csel, B[AW-1:0]=target.
- COND  in  NCOND  condition flags (CY, zero, negative, ...).
- MAP_ADDR  in  AW  opcode-map entry address for the LOAD op.
- UPC  out  AW  microprogram counter (ROM address).
- pre_load  out  1  registered: last executed instruction redirected UPC away from UPC+1.
- is_BSR  out  1  registered: last executed instruction was a BSR that pushed.
- is_RET  out  1  registered: last executed instruction was a RET that popped.
- sp  out  clog2(DEPTH+1)  stack occupancy, 0..DEPTH.
- stack_ovf  out  1  sticky: push attempted while full.
- stack_unf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, RST=1): UPC=0, sp=0, pre_load=is_BSR=is_RET=0, stack_ovf=stack_unf=0. Stack contents are don't-care.
- Hold=1 at the edge: no register changes. Stack, flags and all outputs are held.
- Hold=0: one instruction executes per cycle. B is the word at the current UPC; the new UPC and all flags are visible one cycle later.
- Condition: c = COND[csel]. csel >= NCOND gives c = 0.
- inc = UPC+1 modulo 2^AW; UPC 2^AW-1 wraps to 0.
- op 000 CONT: UPC<=inc.
- op 001 JMP: UPC<=target.
- op 010 JCC: UPC<=target if c, else inc.
- op 011 JNC: UPC<=target if !c, else inc.
- op 100 BSR: push inc; UPC<=target.
- op 101 RET: pop; UPC<=popped value.
- op 110 BCC: if c, behaves as BSR; else UPC<=inc with no push.
- op 111 LOAD: UPC<=MAP_ADDR.
- pre_load = 1 when the next UPC came from target, the stack or MAP_ADDR. A taken jump whose target equals inc still sets pre_load=1.
- The stack is LIFO. Push writes entry[sp] and sp<=sp+1. Pop reads entry[sp-1] and sp<=sp-1.
- Push with sp==DEPTH: jump still taken, return address discarded, sp unchanged, stack_ovf<=1, is_BSR=0.
- Pop with sp==0: treated as CONT (UPC<=inc, pre_load=0), stack_unf<=1, is_RET=0.
- stack_ovf and stack_unf clear only on RST.
- At most one stack operation per cycle; no simultaneous push/pop encoding exists.
- Reset asserted mid-sequence overrides Hold and any in-flight op immediately.

Test Plan:
1. Reset then CONT x3 -> UPC 0,1,2,3; pre_load=0 throughout; sp=0.
2. UPC=5, JCC csel=0 target=0x40: COND[0]=1 -> UPC=0x40, pre_load=1. Same with COND[0]=0 -> UPC=6, pre_load=0. JNC with COND[0]=0 -> UPC=0x40.
3. Nested BSR at UPC 0x10 (target 0x100) then UPC 0x100 (target 0x200), then RET, RET -> UPC 0x100, 0x200, 0x101, 0x11. sp 1,2,1,0. is_BSR/is_RET pulse once per op.
4. DEPTH=4: 5 consecutive BSR -> sp stays 4, fifth BSR still jumps, stack_ovf=1. RET with sp=0 -> UPC=inc, stack_unf=1. Both flags stay set until RST.
5. UPC=0x3FF CONT -> UPC=0. LOAD with MAP_ADDR=0x2A -> UPC=0x2A, pre_load=1.
6. Hold=1 for 3 cycles while B=JMP 0x80 -> UPC/sp/flags unchanged; Hold=0 -> UPC=0x80. RST asserted during Hold -> UPC=0 asynchronously.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: decodes the sequencing field, selects a condition,
// and owns the microprogram counter plus a LIFO return-address stack.
module micro_sequencer #(
  parameter  int AW    = 10,
  parameter  int NCOND = 4,
  parameter  int DEPTH = 4,
  localparam int CW    = (NCOND > 1) ? $clog2(NCOND) : 1,
  localparam int IW    = 3 + CW + AW,
  localparam int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Hold,
  input  logic [IW-1:0]    B,
  input  logic [NCOND-1:0] COND,
  input  logic [AW-1:0]    MAP_ADDR,
  output logic [AW-1:0]    UPC,
  output logic             pre_load,
  output logic             is_BSR,
  output logic             is_RET,
  output logic [SPW-1:0]   sp,
  output logic             stack_ovf,
  output logic             stack_unf
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_CONT = 3'b000, OP_JMP = 3'b001, OP_JCC = 3'b010, OP_JNC  = 3'b011,
    OP_BSR  = 3'b100, OP_RET = 3'b101, OP_BCC = 3'b110, OP_LOAD = 3'b111
  } op_e;

  op_e           op;
  logic [CW-1:0] csel;
  logic [AW-1:0] target;
  logic          c;

  assign op     = op_e'(B[IW-1 -: 3]);
  assign csel   = B[AW +: CW];
  assign target = B[AW-1:0];

  // Out-of-range selects fall through with c = 0.
  always_comb begin
    c = 1'b0;
    for (int i = 0; i < NCOND; i++)
      if (csel == CW'(i)) c = COND[i];
  end

  logic [AW-1:0]  upc_q, upc_d, inc;
  logic [SPW-1:0] sp_q, sp_d;
  logic           pre_q, pre_d, bsr_q, bsr_d, ret_q, ret_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           push_en;
  logic [AW-1:0]  stk_q [DEPTH];
  logic           full, empty;

  assign inc   = upc_q + AW'(1);
  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  always_comb begin
    upc_d   = inc;
    sp_d    = sp_q;
    pre_d   = 1'b0;
    bsr_d   = 1'b0;
    ret_d   = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    case (op)
      OP_CONT: ;
      OP_JMP: begin upc_d = target; pre_d = 1'b1; end
      OP_JCC: if (c)  begin upc_d = target; pre_d = 1'b1; end
      OP_JNC: if (!c) begin upc_d = target; pre_d = 1'b1; end
      OP_BSR, OP_BCC:
        if (op == OP_BSR || c) begin
          upc_d = target;
          pre_d = 1'b1;
          // A full stack still takes the branch but loses the return address.
          if (full) ovf_d = 1'b1;
          else begin
            push_en = 1'b1;
            sp_d    = sp_q + SPW'(1);
            bsr_d   = 1'b1;
          end
        end
      OP_RET:
        if (empty) unf_d = 1'b1;
        else begin
          upc_d = stk_q[IDXW'(sp_q - SPW'(1))];
          sp_d  = sp_q - SPW'(1);
          pre_d = 1'b1;
          ret_d = 1'b1;
        end
      OP_LOAD: begin upc_d = MAP_ADDR; pre_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      upc_q <= '0;
      sp_q  <= '0;
      pre_q <= 1'b0;
      bsr_q <= 1'b0;
      ret_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!Hold) begin
      upc_q <= upc_d;
      sp_q  <= sp_d;
      pre_q <= pre_d;
      bsr_q <= bsr_d;
      ret_q <= ret_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push_en) stk_q[IDXW'(sp_q)] <= inc;
    end
  end

  assign UPC       = upc_q;
  assign sp        = sp_q;
  assign pre_load  = pre_q;
  assign is_BSR    = bsr_q;
  assign is_RET    = ret_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: vector table, directed stack/hold/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_micro_sequencer;
  localparam int AW = 10, NCOND = 4, DEPTH = 4, CW = 2, IW = 15, SPW = 3;
  localparam int CONT = 0, JMP = 1, JCC = 2, JNC = 3, BSR = 4, RET = 5, BCC = 6, LOAD = 7;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             Hold = 1'b0;
  logic [IW-1:0]    B = '0;
  logic [NCOND-1:0] COND = '0;
  logic [AW-1:0]    MAP_ADDR = '0;
  logic [AW-1:0]    UPC;
  logic             pre_load, is_BSR, is_RET, stack_ovf, stack_unf;
  logic [SPW-1:0]   sp;

  micro_sequencer #(.AW(AW), .NCOND(NCOND), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .Hold(Hold), .B(B), .COND(COND), .MAP_ADDR(MAP_ADDR),
    .UPC(UPC), .pre_load(pre_load), .is_BSR(is_BSR), .is_RET(is_RET),
    .sp(sp), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  typedef struct {
    int pre_upc, op, csel, tgt, cond, map;
    int e_upc, e_pre, e_sp, e_bsr, e_ret, e_unf;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(int pu, int op, int cs, int tg, int cd, int mp,
                      int eu, int ep, int es, int eb, int er, int ef);
    vec_t v;
    v = '{pu, op, cs, tg, cd, mp, eu, ep, es, eb, er, ef};
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chkall(string nm, int u, int p, int s, int b, int r, int o, int f);
    chk({nm, ".upc"}, int'(UPC), u);
    chk({nm, ".sp"}, int'(sp), s);
    chk({nm, ".flags"}, int'({pre_load, is_BSR, is_RET, stack_ovf, stack_unf}),
        int'({p[0], b[0], r[0], o[0], f[0]}));
  endtask

  task automatic step(int op, int cs, int tg, int cd, int mp, bit hold);
    B        = {3'(op), CW'(cs), AW'(tg)};
    COND     = NCOND'(cd);
    MAP_ADDR = AW'(mp);
    Hold     = hold;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    Hold = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    // pre_upc, op, csel, tgt, cond, map -> upc, pre, sp, bsr, ret, unf
    addv(5,     JCC,  0, 'h40, 1,     0,    'h40, 1, 0, 0, 0, 0);
    addv(5,     JCC,  0, 'h40, 0,     0,    6,    0, 0, 0, 0, 0);
    addv(5,     JNC,  0, 'h40, 0,     0,    'h40, 1, 0, 0, 0, 0);
    addv(5,     JNC,  0, 'h40, 1,     0,    6,    0, 0, 0, 0, 0);
    addv('h3FF, CONT, 0, 0,    0,     0,    0,    0, 0, 0, 0, 0);
    addv(7,     LOAD, 0, 0,    0,     'h2A, 'h2A, 1, 0, 0, 0, 0);
    addv('h3FF, JCC,  3, 0,    'b1000, 0,   0,    1, 0, 0, 0, 0);
    addv('h10,  JMP,  0, 'h11, 0,     0,    'h11, 1, 0, 0, 0, 0);
    addv(9,     JCC,  2, 'h77, 'b0011, 0,   10,   0, 0, 0, 0, 0);
    addv(9,     BCC,  1, 'h90, 'b1101, 0,   10,   0, 0, 0, 0, 0);
    addv('h50,  BCC,  1, 'h90, 'b0010, 0,   'h90, 1, 1, 1, 0, 0);
    addv(4,     RET,  0, 'h99, 0,     0,    5,    0, 0, 0, 0, 1);

    // Reset state and straight-line CONT
    do_reset();
    chkall("reset", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(CONT, 0, 'h155, 'hF, 0, 0);
      chkall($sformatf("cont%0d", i), i, 0, 0, 0, 0, 0, 0);
    end

    foreach (tbl[i]) begin
      do_reset();
      step(JMP, 0, tbl[i].pre_upc, 0, 0, 0);
      step(tbl[i].op, tbl[i].csel, tbl[i].tgt, tbl[i].cond, tbl[i].map, 0);
      chkall($sformatf("vec%0d", i), tbl[i].e_upc, tbl[i].e_pre, tbl[i].e_sp,
             tbl[i].e_bsr, tbl[i].e_ret, 0, tbl[i].e_unf);
    end

    // Nested call / return
    do_reset();
    step(JMP, 0, 'h10, 0, 0, 0);
    step(BSR, 0, 'h100, 0, 0, 0);  chkall("nest.bsr1", 'h100, 1, 1, 1, 0, 0, 0);
    step(BSR, 0, 'h200, 0, 0, 0);  chkall("nest.bsr2", 'h200, 1, 2, 1, 0, 0, 0);
    step(RET, 0, 'h3AA, 0, 0, 0);  chkall("nest.ret1", 'h101, 1, 1, 0, 1, 0, 0);
    step(RET, 0, 'h3AA, 0, 0, 0);  chkall("nest.ret2", 'h11, 1, 0, 0, 1, 0, 0);
    step(CONT, 0, 0, 0, 0, 0);     chkall("nest.after", 'h12, 0, 0, 0, 0, 0, 0);

    // Overflow on the fifth push, drain, then underflow; both flags sticky
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(BSR, 0, 'h20 + i, 0, 0, 0);
      chkall($sformatf("ovf.push%0d", i), 'h20 + i, 1, i + 1, 1, 0, 0, 0);
    end
    step(BSR, 0, 'h24, 0, 0, 0);   chkall("ovf.full", 'h24, 1, 4, 0, 0, 1, 0);
    step(RET, 0, 0, 0, 0, 0);      chkall("ovf.pop0", 'h23, 1, 3, 0, 1, 1, 0);
    step(RET, 0, 0, 0, 0, 0);      chkall("ovf.pop1", 'h22, 1, 2, 0, 1, 1, 0);
    step(RET, 0, 0, 0, 0, 0);      chkall("ovf.pop2", 'h21, 1, 1, 0, 1, 1, 0);
    step(RET, 0, 0, 0, 0, 0);      chkall("ovf.pop3", 'h01, 1, 0, 0, 1, 1, 0);
    step(RET, 0, 'h3C0, 0, 0, 0);  chkall("unf.empty", 'h02, 0, 0, 0, 0, 1, 1);
    step(CONT, 0, 0, 0, 0, 0);     chkall("sticky", 'h03, 0, 0, 0, 0, 1, 1);
    step(JMP, 0, 'h44, 0, 0, 0);   chkall("sticky2", 'h44, 1, 0, 0, 0, 1, 1);
    do_reset();                    chkall("sticky.rst", 0, 0, 0, 0, 0, 0, 0);

    // Hold freezes everything; reset during hold acts at once
    step(BSR, 0, 'h33, 0, 0, 0);   chkall("hold.pre", 'h33, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(JMP, 0, 'h80, 'hF, 0, 1);
      chkall($sformatf("hold%0d", i), 'h33, 1, 1, 1, 0, 0, 0);
    end
    step(JMP, 0, 'h80, 0, 0, 0);   chkall("hold.release", 'h80, 1, 1, 0, 0, 0, 0);
    Hold = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    chkall("async.rst", 0, 0, 0, 0, 0, 0, 0);
    #1;
    RST  = 1'b0;
    Hold = 1'b0;

    // Randomized run against a queue-based model
    do_reset();
    begin
      int mupc, q[$];
      bit mpre, mbsr, mret, movf, munf;
      mupc = 0; mpre = 0; mbsr = 0; mret = 0; movf = 0; munf = 0;
      for (int n = 0; n < 600; n++) begin
        int op, cs, tg, cd, mp, inc;
        bit hold, c, take;
        op   = $urandom_range(0, 7);
        cs   = $urandom_range(0, NCOND - 1);
        tg   = $urandom_range(0, (1 << AW) - 1);
        cd   = $urandom_range(0, (1 << NCOND) - 1);
        mp   = $urandom_range(0, (1 << AW) - 1);
        hold = ($urandom_range(0, 7) == 0);
        step(op, cs, tg, cd, mp, hold);
        if (!hold) begin
          inc  = (mupc + 1) % (1 << AW);
          c    = ((cd >> cs) & 1) != 0;
          mpre = 0; mbsr = 0; mret = 0;
          take = 0;
          case (op)
            CONT: mupc = inc;
            JMP:  take = 1;
            JCC:  take = c;
            JNC:  take = !c;
            LOAD: begin mupc = mp; mpre = 1; end
            BSR, BCC:
              if (op == BSR || c) begin
                if (q.size() == DEPTH) movf = 1;
                else begin q.push_back(inc); mbsr = 1; end
                take = 1;
              end else mupc = inc;
            RET:
              if (q.size() == 0) begin munf = 1; mupc = inc; end
              else begin mupc = q.pop_back(); mpre = 1; mret = 1; end
            default: ;
          endcase
          if (op inside {JMP, JCC, JNC}) mupc = take ? tg : inc;
          if (op inside {BSR, BCC} && take) begin mupc = tg; mpre = 1; end
          if (op inside {JMP, JCC, JNC} && take) mpre = 1;
        end
        chkall($sformatf("rnd%0d", n), mupc, mpre, q.size(), mbsr, mret, movf, munf);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
